fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_ctrl_pkg.sv | 28 ++
 rtl/rr_pick.sv | 48 ++++
 rtl/fifo_wr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared definitions for the FIFO write-side arbitration logic.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, BURST)
//   clog2()     : ceiling log2, usable in constant expressions such as port
//                 widths (clog2(1) = 0)
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational masked round-robin priority pick.
// The lowest-indexed request at or above ptr wins; if none exists the search
// wraps and the lowest-indexed request overall wins.
// Parameters:
//   N  : number of requesters
//   PW : pointer width, must be able to hold N-1
// Ports:
//   req    [N-1:0]  in  : request vector
//   ptr    [PW-1:0] in  : search start index (0..N-1)
//   winner [N-1:0]  out : one-hot winner (all zero when no request)
//   valid           out : at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          valid
);

    logic [N-1:0] upper_mask;
    logic [N-1:0] masked_req;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign upper_mask[gi] = (PW'(gi) >= ptr);
        end
    endgenerate

    assign masked_req = req & upper_mask;

    // x & (~x + 1) isolates the lowest set bit of x.
    always_comb begin
        if (masked_req != '0) begin
            winner = masked_req & (~masked_req + N'(1));
        end else begin
            winner = req & (~req + N'(1));
        end
    end

    assign valid = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter that lets N_REQ requesters write into one downstream
// FIFO. Free FIFO slots are tracked with a credit counter so the FIFO is never
// overrun, independent of its (lagging) full flag. Grant, write strobe and
// write data are registered and appear one cycle after the sampled request.
//
// Optional feature (macro FIFO_ARB_BURST_EN): the current winner may keep the
// grant for up to MAX_BURST consecutive beats while its request stays high.
// Without the macro the arbiter is strict single-beat round-robin.
//
// Ports:
//   clk         in  : clock, rising edge
//   reset       in  : asynchronous, active-high reset
//   req         in  : per-requester write request (level)
//   req_data    in  : packed request data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt         out : one-hot registered grant (word accepted this cycle)
//   fifo_wr_en  out : registered FIFO write strobe
//   fifo_din    out : registered FIFO write data (holds when idle)
//   fifo_rd_en  in  : consumer read strobe of the same FIFO (credit return)
//   credits     out : free FIFO slots as tracked by the arbiter
//
// The downstream FIFO must be reset together with this block, otherwise the
// credit count and the FIFO occupancy disagree.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_REQ-1:0]                 req,
    input  logic [N_REQ*DATA_WIDTH-1:0]      req_data,
    output logic [N_REQ-1:0]                 gnt,
    output logic                             fifo_wr_en,
    output logic [DATA_WIDTH-1:0]            fifo_din,
    input  logic                             fifo_rd_en,
    output logic [clog2(FIFO_DEPTH+1)-1:0]   credits
);

    localparam int PW = clog2(N_REQ);
    localparam int CW = clog2(FIFO_DEPTH + 1);
    localparam int BW = clog2(MAX_BURST + 1);

`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    arb_state_t              state_reg, state_next;
    logic [PW-1:0]           ptr_reg, ptr_next;
    logic [PW-1:0]           last_reg, last_next;
    logic [BW-1:0]           burst_cnt_reg, burst_cnt_next;
    logic [CW-1:0]           credits_reg, credits_next;
    logic [N_REQ-1:0]        gnt_reg, gnt_next;
    logic                    wr_en_reg, wr_en_next;
    logic [DATA_WIDTH-1:0]   din_reg, din_next;

    logic [N_REQ-1:0]        pick_onehot;
    logic                    any_req;
    logic                    can_write;
    logic                    keep;
    logic                    grant;
    logic                    rd_ok;
    logic [N_REQ-1:0]        win_onehot;
    logic [PW-1:0]           win_idx;
    logic [DATA_WIDTH-1:0]   win_word;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .winner (pick_onehot),
        .valid  (any_req)
    );

    assign can_write = (credits_reg != '0);

    // A burst continues only if the previous cycle granted (state not IDLE),
    // the same requester still asks, and its beat budget is not used up.
    // With the feature disabled BURST_EN is constant zero and BURST is
    // unreachable.
    assign keep = BURST_EN && (state_reg != IDLE) && req[last_reg]
                  && (burst_cnt_reg < BW'(MAX_BURST));

    // A credit returns only if the arbiter thinks something is stored; a read
    // of an empty FIFO must not create a phantom slot.
    assign rd_ok = fifo_rd_en && (credits_reg != CW'(FIFO_DEPTH));

    // Winner selection and its data word.
    always_comb begin
        win_onehot = '0;
        if (keep) begin
            win_onehot[last_reg] = 1'b1;
        end else begin
            win_onehot = pick_onehot;
        end
        win_idx  = '0;
        win_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_onehot[i]) begin
                win_idx  = PW'(i);
                win_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (any_req && can_write) begin
                    state_next = GRANT;
                end
            end
            GRANT, BURST: begin
                if (!any_req || !can_write) begin
                    state_next = IDLE;
                end else if (keep) begin
                    state_next = BURST;
                end else begin
                    state_next = GRANT;
                end
            end
            default: state_next = IDLE;
        endcase

        grant          = (state_next != IDLE);
        gnt_next       = '0;
        wr_en_next     = 1'b0;
        din_next       = din_reg;
        ptr_next       = ptr_reg;
        last_next      = last_reg;
        burst_cnt_next = '0;

        if (grant) begin
            gnt_next   = win_onehot;
            wr_en_next = 1'b1;
            din_next   = win_word;
            last_next  = win_idx;
            ptr_next   = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
            burst_cnt_next = keep ? burst_cnt_reg + BW'(1) : BW'(1);
        end

        credits_next = credits_reg;
        case ({grant, rd_ok})
            2'b10:   credits_next = credits_reg - CW'(1);
            2'b01:   credits_next = credits_reg + CW'(1);
            default: credits_next = credits_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            last_reg      <= '0;
            burst_cnt_reg <= '0;
            credits_reg   <= CW'(FIFO_DEPTH);
            gnt_reg       <= '0;
            wr_en_reg     <= 1'b0;
            din_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            last_reg      <= last_next;
            burst_cnt_reg <= burst_cnt_next;
            credits_reg   <= credits_next;
            gnt_reg       <= gnt_next;
            wr_en_reg     <= wr_en_next;
            din_reg       <= din_next;
        end
    end

    assign gnt        = gnt_reg;
    assign fifo_wr_en = wr_en_reg;
    assign fifo_din   = din_reg;
    assign credits    = credits_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int DW    = 8;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int MAXB  = 4;

`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            fifo_rd_en;
    logic [N-1:0]    gnt;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_din;
    logic [2:0]      credits;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .N_REQ      (N),
        .FIFO_DEPTH (DEPTH),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_rd_en (fifo_rd_en),
        .credits    (credits)
    );

    always #5 clk = ~clk;

    int tests;
    int fails;

    // Reference model: round-robin search position, last winner, length of the
    // current run of consecutive grants, FIFO occupancy and an in-flight word.
    int            m_ptr, m_last, m_run, m_cnt, m_infl;
    logic [N-1:0]  exp_gnt;
    logic          exp_wr;
    logic [DW-1:0] exp_din;
    int            exp_credits;

    logic [DW-1:0] sb[$];      // words accepted, in acceptance order
    logic [DW-1:0] fifo_q[$];  // downstream FIFO fed by the DUT outputs
    int            sb_err, overflow, underflow;

    task automatic model_clear();
        m_ptr = 0; m_last = 0; m_run = 0; m_cnt = 0; m_infl = 0;
        exp_gnt = '0; exp_wr = 1'b0; exp_din = '0; exp_credits = DEPTH;
        sb.delete(); fifo_q.delete();
        sb_err = 0; overflow = 0; underflow = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = '0; fifo_rd_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // Advance one clock: predict the DUT's registered outputs after the edge,
    // feed the downstream FIFO model from the DUT's current outputs, then land
    // on the following negedge.
    task automatic cycle();
        int cred_before, winner, idx;
        bit rd_valid, kept;
        logic [DW-1:0] w;
        cred_before = DEPTH - m_cnt - m_infl;
        rd_valid    = fifo_rd_en && (m_cnt > 0);
        winner      = -1;
        kept        = 1'b0;
        if (cred_before > 0 && req != '0) begin
            if (BURST && m_run > 0 && m_run < MAXB && req[m_last]) begin
                winner = m_last;
                kept   = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (winner < 0 && req[idx]) winner = idx;
                end
            end
        end
        if (winner >= 0) begin
            exp_gnt = '0;
            exp_gnt[winner] = 1'b1;
            exp_wr  = 1'b1;
            exp_din = req_data[winner*DW +: DW];
            sb.push_back(exp_din);
            m_run   = kept ? m_run + 1 : 1;
            m_last  = winner;
            m_ptr   = (winner + 1) % N;
        end else begin
            exp_gnt = '0;
            exp_wr  = 1'b0;
            m_run   = 0;
        end
        m_cnt       = m_cnt - int'(rd_valid) + m_infl;
        m_infl      = (winner >= 0) ? 1 : 0;
        exp_credits = DEPTH - m_cnt - m_infl;

        if (fifo_rd_en && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            if (sb.size() == 0 || sb[0] !== w) sb_err++;
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (rd_valid) begin
            underflow++;
        end
        if (fifo_wr_en) begin
            fifo_q.push_back(fifo_din);
            if (fifo_q.size() > DEPTH) overflow++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic refresh_granted();
        for (int i = 0; i < N; i++) begin
            if (exp_gnt[i]) req_data[i*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        tests++; if (fifo_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); end
        tests++; if (fifo_din !== 8'h00) begin fails++; $display("FAIL reset_din got %h want 00", fifo_din); end
        tests++; if (credits !== 3'd4) begin fails++; $display("FAIL reset_credits got %0d want 4", credits); end
        // Reads of an empty FIFO must not create credits.
        fifo_rd_en = 1'b1;
        cycle();
        cycle();
        fifo_rd_en = 1'b0;
        tests++; if (credits !== 3'd4) begin fails++; $display("FAIL empty_read_credits got %0d want 4", credits); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_rr_sequence();
        logic [N-1:0] seq [5];
`ifdef FIFO_ARB_BURST_EN
        seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
`else
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
`endif
        do_reset();
        req = 4'b1111; req_data = $urandom; fifo_rd_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            tests++; if (gnt !== seq[k]) begin fails++; $display("FAIL rr_seq[%0d] got %b want %b", k, gnt, seq[k]); end
            tests++; if (fifo_din !== exp_din) begin fails++; $display("FAIL rr_din[%0d] got %h want %h", k, fifo_din, exp_din); end
            refresh_granted();
        end
        tests++; if (credits !== 3'd0) begin fails++; $display("FAIL rr_credits got %0d want 0", credits); end
        $display("[TB] test_rr_sequence done");
    endtask

    task automatic test_credit_return();
        int grants;
        grants = 0;
        fifo_rd_en = 1'b1;
        cycle();
        fifo_rd_en = 1'b0;
        tests++; if (credits !== 3'd1) begin fails++; $display("FAIL cr_after_read got %0d want 1", credits); end
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (gnt != '0) grants++;
            tests++; if (gnt !== exp_gnt) begin fails++; $display("FAIL cr_gnt[%0d] got %b want %b", k, gnt, exp_gnt); end
            refresh_granted();
        end
        tests++; if (grants !== 1) begin fails++; $display("FAIL cr_grant_count got %0d want 1", grants); end
        tests++; if (credits !== 3'd0) begin fails++; $display("FAIL cr_credits_end got %0d want 0", credits); end
        $display("[TB] test_credit_return done");
    endtask

    // Two requesters held high: the order follows round-robin (or bursts of
    // MAXB when bursting is built in), one write every cycle.
    task automatic test_pair(input logic [N-1:0] pattern, input int lo, input int hi,
                             input int ncyc, input string name);
        int g;
        logic [N-1:0] want;
        do_reset();
        req = pattern; req_data = $urandom;
        g = 0;
        for (int k = 0; k < ncyc; k++) begin
            fifo_rd_en = (m_cnt > 0);
            cycle();
            tests++; if (gnt !== exp_gnt) begin fails++; $display("FAIL %s_model[%0d] got %b want %b", name, k, gnt, exp_gnt); end
            if (gnt != '0) begin
                want = '0;
                want[(((BURST ? g / MAXB : g) % 2) == 1) ? hi : lo] = 1'b1;
                tests++; if (gnt !== want) begin fails++; $display("FAIL %s_order[%0d] got %b want %b", name, g, gnt, want); end
                g++;
            end
            refresh_granted();
        end
        fifo_rd_en = 1'b0;
        tests++; if (g !== ncyc) begin fails++; $display("FAIL %s_rate got %0d grants want %0d", name, g, ncyc); end
        tests++; if (sb_err !== 0) begin fails++; $display("FAIL %s_data got %0d errors want 0", name, sb_err); end
        $display("[TB] test_%s done, %0d grants", name, g);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = 4'b0011; req_data = $urandom;
        for (int k = 0; k < 3; k++) begin
            fifo_rd_en = (m_cnt > 0);
            cycle();
            refresh_granted();
        end
        tests++; if (gnt !== exp_gnt || gnt == '0) begin fails++; $display("FAIL mid_third_beat got %b want %b", gnt, exp_gnt); end
        reset = 1'b1;
        #1;
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL mid_rst_gnt got %b want 0000", gnt); end
        tests++; if (fifo_wr_en !== 1'b0) begin fails++; $display("FAIL mid_rst_wr got %b want 0", fifo_wr_en); end
        tests++; if (fifo_din !== 8'h00) begin fails++; $display("FAIL mid_rst_din got %h want 00", fifo_din); end
        tests++; if (credits !== 3'd4) begin fails++; $display("FAIL mid_rst_credits got %0d want 4", credits); end
        @(posedge clk);
        #1;
        tests++; if (fifo_wr_en !== 1'b0) begin fails++; $display("FAIL mid_rst_hold_wr got %b want 0", fifo_wr_en); end
        @(negedge clk);
        reset = 1'b0; req = '0; fifo_rd_en = 1'b0;
        model_clear();
        cycle();
        tests++; if (credits !== 3'd4) begin fails++; $display("FAIL mid_release_credits got %0d want 4", credits); end
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL mid_release_gnt got %b want 0000", gnt); end
        $display("[TB] test_reset_mid_burst done");
    endtask

    task automatic test_random();
        int pct, writes;
        do_reset();
        req = '0; req_data = $urandom; writes = 0;
        for (int c = 0; c < 10000; c++) begin
            case ((c / 500) % 4)
                0:       pct = 100;
                1:       pct = 50;
                2:       pct = 10;
                default: pct = 0;
            endcase
            fifo_rd_en = (m_cnt > 0) && ($urandom_range(99) < pct);
            cycle();
            if (exp_wr) writes++;
            tests++; if (gnt !== exp_gnt) begin fails++; $display("FAIL rnd_gnt[%0d] got %b want %b", c, gnt, exp_gnt); end
            tests++; if (fifo_wr_en !== exp_wr) begin fails++; $display("FAIL rnd_wr[%0d] got %b want %b", c, fifo_wr_en, exp_wr); end
            tests++; if (fifo_din !== exp_din) begin fails++; $display("FAIL rnd_din[%0d] got %h want %h", c, fifo_din, exp_din); end
            tests++; if (credits !== 3'(exp_credits)) begin fails++; $display("FAIL rnd_credits[%0d] got %0d want %0d", c, credits, exp_credits); end
            for (int i = 0; i < N; i++) begin
                if (exp_gnt[i]) begin
                    req_data[i*DW +: DW] = DW'($urandom);
                    req[i] = ($urandom_range(3) != 0);
                end else if (!req[i]) begin
                    if ($urandom_range(2) == 0) begin
                        req[i] = 1'b1;
                        req_data[i*DW +: DW] = DW'($urandom);
                    end
                end else if ($urandom_range(15) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        fifo_rd_en = 1'b0;
        tests++; if (sb_err !== 0) begin fails++; $display("FAIL rnd_order got %0d errors want 0", sb_err); end
        tests++; if (overflow !== 0) begin fails++; $display("FAIL rnd_overflow got %0d want 0", overflow); end
        tests++; if (underflow !== 0) begin fails++; $display("FAIL rnd_underflow got %0d want 0", underflow); end
        $display("[TB] test_random done, %0d writes", writes);
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; req = '0; req_data = '0; fifo_rd_en = 1'b0;
        model_clear();
        test_reset();
        test_rr_sequence();
        test_credit_return();
        test_pair(4'b0101, 0, 2, 40, "alternate");
        test_pair(4'b0011, 0, 1, 16, "burst");
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
